// File: rtl/systolic_row_feeder.sv
// Pops K_LEN elements from each row FIFO and launches them into the array as a diagonal wavefront.
// Pop-to-operand latency is one cycle; an empty FIFO inside the active mask freezes every lane.
module systolic_row_feeder #(
  parameter int ROWS  = 4,
  parameter int WIDTH = 8,
  parameter int K_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ROWS-1:0]       fifo_empty,
  input  logic [ROWS*WIDTH-1:0] fifo_data,
  output logic [ROWS-1:0]       fifo_rd_en,
  output logic [ROWS*WIDTH-1:0] arr_data,
  output logic [ROWS-1:0]       arr_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int TW     = $clog2(K_LEN + ROWS);
  localparam int T_LAST = K_LEN + ROWS - 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   t_q, t_d;
  logic [ROWS-1:0] arr_valid_q;
  logic [ROWS-1:0] mask;
  logic            stall;

  // Lane r is live while t lies in [r, r+K_LEN): this is what produces the skew.
  always_comb begin
    mask = '0;
    for (int r = 0; r < ROWS; r++) begin
      mask[r] = (int'(t_q) >= r) && (int'(t_q) < r + K_LEN);
    end
  end

  assign stall = |(mask & fifo_empty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      t_q         <= '0;
      arr_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      arr_valid_q <= fifo_rd_en;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          t_d     = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          if (t_q == TW'(T_LAST)) state_d = DRAIN;
          else                    t_d     = t_q + 1'b1;
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_en = '0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      RUN: begin
        busy       = 1'b1;
        fifo_rd_en = stall ? '0 : mask;
      end
      DRAIN: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign arr_valid = arr_valid_q;

  // FIFO read data is already registered, so gating it with the delayed enable aligns it.
  always_comb begin
    arr_data = '0;
    for (int r = 0; r < ROWS; r++) begin
      arr_data[r*WIDTH +: WIDTH] = arr_valid_q[r] ? fifo_data[r*WIDTH +: WIDTH] : '0;
    end
  end

endmodule

// File: doc/systolic_row_feeder.md
Name: systolic_row_feeder

Overview:
- Sits directly downstream of the per-row input FIFOs. Each FIFO has a registered read-data output, and read data appears on the cycle after the read enable.
- Pops one K_LEN-element operand row per FIFO and presents the rows to the systolic array's left edge with diagonal skew: lane r starts r cycles after lane 0.
- Lanes with no valid data in a cycle carry a zero bubble.
- If any FIFO runs dry mid-tile, the whole wavefront freezes so the skew is never broken.

Parameters:
- ROWS, 4, number of array rows, FIFOs and output lanes.
- WIDTH, 8, operand bit width per lane.
- K_LEN, 4, elements popped from each FIFO per tile (>=1).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin one tile. Sampled only in IDLE; ignored while busy.
- fifo_empty  input  ROWS  per-lane FIFO empty flag.
- fifo_data  input  ROWS*WIDTH  per-lane FIFO read data. Lane r is bits [r*WIDTH +: WIDTH].
- fifo_rd_en  output  ROWS  per-lane FIFO read enable (combinational from state and fifo_empty).
- arr_data  output  ROWS*WIDTH  operands to array. Lane r equals fifo_data lane r when arr_valid[r]=1, else 0.
- arr_valid  output  ROWS  per-lane operand valid, registered.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse in DRAIN.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, t=0, arr_valid=0, done=0, busy=0.
  - Consequently fifo_rd_en=0 and arr_data=0 while rst is high.
  - Reset mid-tile abandons the tile. Already-popped data is not restored.
- States: IDLE, RUN, DRAIN.
- Counter t: width $clog2(K_LEN+ROWS), range 0..K_LEN+ROWS-2.
- IDLE -> RUN when start=1 at a clock edge; t cleared to 0. No FIFO is read in IDLE.
- RUN, lane mask: m[r] = (t >= r) && (t < r+K_LEN).
- RUN, stall: stall = |(m & fifo_empty).
- RUN, read enable: fifo_rd_en = stall ? 0 : m. All lanes pop together or none pop.
- RUN, counter: t increments only when !stall.
- RUN -> DRAIN on a non-stalled cycle with t = K_LEN+ROWS-2.
- DRAIN: fifo_rd_en=0; done=1 for exactly this cycle; next state IDLE.
- arr_valid register: arr_valid <= fifo_rd_en each cycle. Latency from a pop to the operand at the array is exactly 1 cycle.
- A stall cycle yields arr_valid=0 on all lanes in the next cycle. The array must hold its accumulation while arr_valid lanes are 0 and stalls are in progress.
- Per tile: exactly K_LEN pops per lane and ROWS*K_LEN total. Lane r sees its K_LEN valids on consecutive non-stalled cycles, offset r cycles from lane 0.
- Minimum tile time, start edge to done: K_LEN+ROWS cycles, plus the number of stall cycles.
- start asserted in DRAIN or RUN is ignored and not queued. start in the IDLE cycle following DRAIN begins the next tile (back-to-back tiles with one idle cycle).
- fifo_empty on lanes outside the mask never causes a stall.
- The feeder never pops an empty FIFO; fifo_rd_en[r] & fifo_empty[r] is never 1.

Test Plan:
- Basic tile: ROWS=4, K_LEN=4; preload FIFO r with {r*16+0..3}; start pulse at cycle 0. Required response:
  - RUN at cycles 1-7; fifo_rd_en = 0001, 0011, 0111, 1111, 1110, 1100, 1000.
  - arr_valid is the same sequence delayed by 1.
  - Lane 2 outputs 0x20,0x21,0x22,0x23 at cycles 4-7.
  - done=1 at cycle 8; busy low at cycle 9.
- Bubble zeros: same run; every lane with arr_valid=0 must read arr_data=0, including cycle 2 lanes 1-3.
- Stall: FIFO 3 empty until 3 cycles after it is first needed (t=3). Required response:
  - fifo_rd_en=0 on all lanes for those 3 cycles; t holds.
  - arr_valid=0000 on the following cycles.
  - Wavefront resumes with skew intact; done at cycle 11.
- Start while busy: pulse start at cycles 3 and 8. Required response: exactly one tile completes and exactly 16 pops occur. A start at cycle 9 (IDLE) starts a second tile.
- Reset mid-tile: assert rst at t=2 between clock edges. Required response: fifo_rd_en, arr_valid, busy and done go 0 immediately; after release, state is IDLE with no pops until a new start.
- K_LEN=1, ROWS=4: single diagonal; fifo_rd_en = 0001, 0010, 0100, 1000; done 5 cycles after start.
